// File: rtl/register_file.sv
// register_file
//   Architectural register file with rename tracking for an out-of-order core.
//   Each of the 32 entries holds a committed value, a busy flag and the ROB tag
//   of the in-flight producer. Register x0 is hard-wired to zero and never busy.
//
// Ports
//   clk_in            system clock, rising edge
//   rst_in            asynchronous active-low reset
//   rdy_in            ready; low freezes all state
//   issue_valid       decoder renames issue_rd this cycle
//   issue_rd          destination being renamed
//   issue_rob_idx     ROB entry that will produce issue_rd
//   query_rs1/rs2     source registers queried by the decoder
//   query_busy1/2     operand still pending in the ROB
//   query_tag1/2      producing ROB index (meaningful when busy)
//   query_val1/2      committed value (meaningful when not busy)
//   rob_set_idx       commit destination, 0 = no commit
//   rob_set_reg_val   commit value
//   rob_set_recorder  ROB index of the committing entry
//   clear             pipeline flush after branch mispredict
module register_file #(
  parameter int ROB_SIZE_BIT = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,

  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic [ROB_SIZE_BIT-1:0] issue_rob_idx,

  input  logic [4:0]              query_rs1,
  input  logic [4:0]              query_rs2,
  output logic                    query_busy1,
  output logic                    query_busy2,
  output logic [ROB_SIZE_BIT-1:0] query_tag1,
  output logic [ROB_SIZE_BIT-1:0] query_tag2,
  output logic [31:0]             query_val1,
  output logic [31:0]             query_val2,

  input  logic [4:0]              rob_set_idx,
  input  logic [31:0]             rob_set_reg_val,
  input  logic [ROB_SIZE_BIT-1:0] rob_set_recorder,

  input  logic                    clear
);

  logic [31:0]             value_q [32];
  logic                    busy_q  [32];
  logic [ROB_SIZE_BIT-1:0] tag_q   [32];

  logic do_commit;
  logic do_issue;

  assign do_commit = rdy_in && !clear && (rob_set_idx != 5'd0);
  assign do_issue  = rdy_in && !clear && issue_valid && (issue_rd != 5'd0);

  // State update. Entry 0 is never written, so it stays at its reset value.
  // Issue is applied after commit so that a same-register rename wins over
  // the busy clear of a simultaneous commit.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < 32; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (clear) begin
        for (int unsigned i = 0; i < 32; i++) begin
          busy_q[i] <= 1'b0;
        end
      end else begin
        if (do_commit) begin
          value_q[rob_set_idx] <= rob_set_reg_val;
          if (busy_q[rob_set_idx] && (tag_q[rob_set_idx] == rob_set_recorder)) begin
            busy_q[rob_set_idx] <= 1'b0;
          end
        end
        if (do_issue) begin
          busy_q[issue_rd] <= 1'b1;
          tag_q[issue_rd]  <= issue_rob_idx;
        end
      end
    end
  end

  // Combinational read with same-cycle commit bypass. A same-cycle issue is
  // deliberately not visible here.
  logic [4:0]              rs     [2];
  logic                    q_busy [2];
  logic [ROB_SIZE_BIT-1:0] q_tag  [2];
  logic [31:0]             q_val  [2];

  assign rs[0] = query_rs1;
  assign rs[1] = query_rs2;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      q_busy[p] = 1'b0;
      q_tag[p]  = '0;
      q_val[p]  = '0;
      if (rs[p] != 5'd0) begin
        q_busy[p] = busy_q[rs[p]];
        q_tag[p]  = tag_q[rs[p]];
        q_val[p]  = value_q[rs[p]];
        if (busy_q[rs[p]] && (rob_set_idx == rs[p]) &&
            (rob_set_recorder == tag_q[rs[p]])) begin
          q_busy[p] = 1'b0;
          q_val[p]  = rob_set_reg_val;
        end
      end
    end
  end

  assign query_busy1 = q_busy[0];
  assign query_tag1  = q_tag[0];
  assign query_val1  = q_val[0];
  assign query_busy2 = q_busy[1];
  assign query_tag2  = q_tag[1];
  assign query_val2  = q_val[1];

endmodule
